// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Shared state, opcode and ALU encodings for the control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    DECODE   = 3'd2,
    EXEC_LD  = 3'd3,
    EXEC_ST  = 3'd4,
    EXEC_ALU = 3'd5,
    WB       = 3'd6,
    DONE     = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    CLS_LOAD    = 2'd0,
    CLS_STORE   = 2'd1,
    CLS_ALU     = 2'd2,
    CLS_ILLEGAL = 2'd3
  } op_class_t;

  localparam logic [2:0] c_OP_LOAD  = 3'b000;
  localparam logic [2:0] c_OP_STORE = 3'b001;
  localparam logic [2:0] c_OP_OR    = 3'b100;
  localparam logic [2:0] c_OP_ADD   = 3'b101;
  localparam logic [2:0] c_OP_SUB   = 3'b110;
  localparam logic [2:0] c_OP_AND   = 3'b111;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Brief    : Combinational field extraction and opcode classification.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int IW    = 12,
  parameter int OP_W  = 3,
  parameter int RF_AW = 3,
  parameter int DM_AW = 4
) (
  input  logic [IW-1:0]    instr,
  output logic [1:0]       op_class,
  output logic [DM_AW-1:0] addr,
  output logic [RF_AW-1:0] reg_sel,
  output logic [RF_AW-1:0] ra,
  output logic [RF_AW-1:0] rb,
  output logic [RF_AW-1:0] rd,
  output logic [1:0]       alu_op,
  output logic             illegal
);

  logic [OP_W-1:0] w_opcode;

  assign w_opcode = instr[IW-1 -: OP_W];
  assign addr     = instr[DM_AW-1:0];
  assign reg_sel  = instr[DM_AW+RF_AW-1:DM_AW];
  assign ra       = instr[RF_AW-1:0];
  assign rb       = instr[2*RF_AW-1:RF_AW];
  assign rd       = instr[3*RF_AW-1:2*RF_AW];

  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_op   = ALU_ADD;
    illegal  = 1'b0;
    case (w_opcode)
      OP_W'(c_OP_LOAD):  op_class = CLS_LOAD;
      OP_W'(c_OP_STORE): op_class = CLS_STORE;
      OP_W'(c_OP_OR):  begin op_class = CLS_ALU; alu_op = ALU_OR;  end
      OP_W'(c_OP_ADD): begin op_class = CLS_ALU; alu_op = ALU_ADD; end
      OP_W'(c_OP_SUB): begin op_class = CLS_ALU; alu_op = ALU_SUB; end
      OP_W'(c_OP_AND): begin op_class = CLS_ALU; alu_op = ALU_AND; end
      default:           illegal  = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_seq_gen
// Brief    : Multi-cycle load/store/ALU controller with busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_seq_gen
  import ctrl_pkg::*;
#(
  parameter int IW      = 12,
  parameter int OP_W    = 3,
  parameter int RF_AW   = 3,
  parameter int DM_AW   = 4,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ext_sel,
  input  logic [IW-1:0]    switches,
  input  logic [IW-1:0]    ir_out,
  output logic [DM_AW-1:0] D_addr,
  output logic             D_rd,
  output logic             D_wr,
  output logic             RF_we,
  output logic [RF_AW-1:0] RF_waddr,
  output logic [RF_AW-1:0] ra,
  output logic [RF_AW-1:0] rb,
  output logic             is_external,
  output logic [1:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int c_LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  generate
    if ((3*RF_AW + OP_W > IW) || (DM_AW + RF_AW + OP_W > IW) || (MEM_LAT < 1)) begin : g_param_check
      $fatal(1, "ctrl_seq_gen: instruction fields exceed IW or MEM_LAT < 1");
    end
  endgenerate

  state_t             r_state;
  state_t             w_next_state;
  logic [IW-1:0]      r_instr;
  logic [c_LAT_W-1:0] r_wait;
  logic               r_illegal;
  logic [CNT_W-1:0]   r_instr_cnt;

  logic [1:0]         w_op_class;
  logic [DM_AW-1:0]   w_addr;
  logic [RF_AW-1:0]   w_reg;
  logic [RF_AW-1:0]   w_ra;
  logic [RF_AW-1:0]   w_rb;
  logic [RF_AW-1:0]   w_rd;
  logic [1:0]         w_alu_op;
  logic               w_illegal;

  ctrl_decode #(
    .IW    (IW),
    .OP_W  (OP_W),
    .RF_AW (RF_AW),
    .DM_AW (DM_AW)
  ) u_decode (
    .instr    (r_instr),
    .op_class (w_op_class),
    .addr     (w_addr),
    .reg_sel  (w_reg),
    .ra       (w_ra),
    .rb       (w_rb),
    .rd       (w_rd),
    .alu_op   (w_alu_op),
    .illegal  (w_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Datapath registers advance only on the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr     <= '0;
      r_wait      <= '0;
      r_illegal   <= 1'b0;
      r_instr_cnt <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          r_instr   <= ext_sel ? switches : ir_out;
          r_illegal <= 1'b0;
        end
        DECODE: begin
          r_wait <= c_LAT_W'(MEM_LAT - 1);
          if (w_illegal) r_illegal <= 1'b1;
        end
        EXEC_LD: begin
          if (r_wait != '0) r_wait <= r_wait - c_LAT_W'(1);
        end
        DONE: begin
          if (!r_illegal) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (start) w_next_state = FETCH;
      FETCH:    w_next_state = DECODE;
      DECODE: begin
        if (w_illegal)                    w_next_state = DONE;
        else if (w_op_class == CLS_LOAD)  w_next_state = EXEC_LD;
        else if (w_op_class == CLS_STORE) w_next_state = EXEC_ST;
        else                              w_next_state = EXEC_ALU;
      end
      EXEC_LD:  if (r_wait == '0) w_next_state = WB;
      EXEC_ST:  w_next_state = DONE;
      EXEC_ALU: w_next_state = DONE;
      WB:       w_next_state = DONE;
      DONE:     w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  always_comb begin
    D_addr      = '0;
    D_rd        = 1'b0;
    D_wr        = 1'b0;
    RF_we       = 1'b0;
    RF_waddr    = '0;
    ra          = '0;
    rb          = '0;
    is_external = 1'b0;
    alu_op      = 2'b00;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      FETCH, DECODE: busy = 1'b1;
      EXEC_LD: begin
        busy   = 1'b1;
        D_rd   = 1'b1;
        D_addr = w_addr;
      end
      WB: begin
        busy        = 1'b1;
        RF_we       = 1'b1;
        is_external = 1'b1;
        RF_waddr    = w_reg;
        D_addr      = w_addr;
      end
      EXEC_ST: begin
        busy   = 1'b1;
        D_wr   = 1'b1;
        D_addr = w_addr;
        ra     = w_reg;
      end
      EXEC_ALU: begin
        busy     = 1'b1;
        RF_we    = 1'b1;
        ra       = w_ra;
        rb       = w_rb;
        RF_waddr = w_rd;
        alu_op   = w_alu_op;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign illegal   = r_illegal;
  assign instr_cnt = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_seq_gen
// Brief    : Scoreboard bench comparing every busy cycle against a trace model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_seq_gen;

  localparam int IW      = 12;
  localparam int OP_W    = 3;
  localparam int RF_AW   = 3;
  localparam int DM_AW   = 4;
  localparam int MEM_LAT = 3;
  localparam int CNT_W   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             ext_sel;
  logic [IW-1:0]    switches;
  logic [IW-1:0]    ir_out;
  logic [DM_AW-1:0] D_addr;
  logic             D_rd, D_wr, RF_we, is_external, busy, done, illegal;
  logic [RF_AW-1:0] RF_waddr, ra, rb;
  logic [1:0]       alu_op;
  logic [CNT_W-1:0] instr_cnt;

  always #5 clk = ~clk;

  ctrl_seq_gen #(
    .IW(IW), .OP_W(OP_W), .RF_AW(RF_AW), .DM_AW(DM_AW), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ext_sel(ext_sel), .switches(switches),
    .ir_out(ir_out), .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr), .RF_we(RF_we),
    .RF_waddr(RF_waddr), .ra(ra), .rb(rb), .is_external(is_external), .alu_op(alu_op),
    .busy(busy), .done(done), .illegal(illegal), .instr_cnt(instr_cnt)
  );

  typedef struct packed {
    logic [DM_AW-1:0] d_addr;
    logic             d_rd;
    logic             d_wr;
    logic             rf_we;
    logic [RF_AW-1:0] rf_waddr;
    logic [RF_AW-1:0] ra;
    logic [RF_AW-1:0] rb;
    logic             is_ext;
    logic [1:0]       alu_op;
    logic             busy;
    logic             done;
    logic             illegal;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  obs_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_cnt     = 0;
  logic m_illegal = 1'b0;

  function automatic obs_t sample();
    obs_t o;
    o = {D_addr, D_rd, D_wr, RF_we, RF_waddr, ra, rb, is_external, alu_op,
         busy, done, illegal, instr_cnt};
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  function automatic obs_t idle_entry();
    obs_t e;
    e = '0;
    e.cnt     = CNT_W'(m_cnt);
    e.illegal = m_illegal;
    return e;
  endfunction

  // Expected outputs for FETCH..DONE plus the trailing IDLE cycle, from the opcode rules.
  task automatic push_trace(input logic [IW-1:0] instr, output int len);
    obs_t e;
    logic [2:0]       op;
    logic [DM_AW-1:0] addr;
    logic [RF_AW-1:0] rg, sa, sb, dst;
    bit               legal;
    op    = instr[11:9];
    addr  = instr[3:0];
    rg    = instr[6:4];
    sa    = instr[2:0];
    sb    = instr[5:3];
    dst   = instr[8:6];
    legal = !(op == 3'b010 || op == 3'b011);
    len   = 0;
    e = idle_entry(); e.busy = 1'b1;
    sb_q.push_back(e); len++;
    e.illegal = 1'b0;
    sb_q.push_back(e); len++;
    if (op == 3'b000) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        e = '0; e.cnt = CNT_W'(m_cnt); e.busy = 1'b1; e.d_rd = 1'b1; e.d_addr = addr;
        sb_q.push_back(e); len++;
      end
      e = '0; e.cnt = CNT_W'(m_cnt); e.busy = 1'b1; e.rf_we = 1'b1; e.is_ext = 1'b1;
      e.rf_waddr = rg; e.d_addr = addr;
      sb_q.push_back(e); len++;
    end else if (op == 3'b001) begin
      e = '0; e.cnt = CNT_W'(m_cnt); e.busy = 1'b1; e.d_wr = 1'b1; e.d_addr = addr; e.ra = rg;
      sb_q.push_back(e); len++;
    end else if (legal) begin
      e = '0; e.cnt = CNT_W'(m_cnt); e.busy = 1'b1; e.rf_we = 1'b1;
      e.ra = sa; e.rb = sb; e.rf_waddr = dst;
      case (op)
        3'b100:  e.alu_op = 2'b11;
        3'b101:  e.alu_op = 2'b00;
        3'b110:  e.alu_op = 2'b01;
        default: e.alu_op = 2'b10;
      endcase
      sb_q.push_back(e); len++;
    end
    e = '0; e.cnt = CNT_W'(m_cnt); e.done = 1'b1; e.illegal = !legal;
    sb_q.push_back(e); len++;
    if (legal) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    m_illegal = !legal;
    sb_q.push_back(idle_entry()); len++;
  endtask

  // Called at a negedge while the DUT is IDLE; returns at the negedge of the following IDLE cycle.
  task automatic run(input logic sel, input logic [IW-1:0] sw, input logic [IW-1:0] ir,
                     input bit extras);
    int len;
    push_trace(sel ? sw : ir, len);
    ext_sel  = sel;
    switches = sw;
    ir_out   = ir;
    start    = 1'b1;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      start = (extras && k < len) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k >= 2) begin
        ext_sel  = 1'($urandom_range(0, 1));
        switches = IW'($urandom_range(0, 4095));
        ir_out   = IW'($urandom_range(0, 4095));
      end
    end
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < n; k++) begin
      start = 1'b0;
      sb_q.push_back(idle_entry());
      @(negedge clk);
    end
  endtask

  task automatic reset_mid_load();
    obs_t z;
    z = '0;
    ext_sel = 1'b0; ir_out = 12'h059; switches = '0;
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (D_rd !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_rd got=%b expected=1", D_rd);
    end
    reset = 1'b1;
    #1;
    check_obs("async_reset_outputs", sample(), z);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_obs("held_reset_outputs", sample(), z);
    end
    reset     = 1'b0;
    m_cnt     = 0;
    m_illegal = 1'b0;
    gap(2);
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_obs("trace", sample(), e);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [IW-1:0] ins;
    obs_t z;
    z = '0;
    reset = 1'b1; start = 1'b0; ext_sel = 1'b0; switches = '0; ir_out = '0;
    #1;
    check_obs("reset_state", sample(), z);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    gap(2);

    run(1'b0, 12'h000, 12'h059, 1'b0);
    run(1'b1, 12'hA8C, 12'hFFF, 1'b0);
    run(1'b1, 12'hC8C, 12'hFFF, 1'b0);
    run(1'b0, 12'hFFF, 12'h237, 1'b1);
    gap(1);
    run(1'b0, 12'h000, 12'h600, 1'b0);
    run(1'b0, 12'h000, 12'hE3F, 1'b0);
    reset_mid_load();

    for (int n = 0; n < 5; n++) begin
      do ins = IW'($urandom_range(0, 4095));
      while (ins[11:9] == 3'b010 || ins[11:9] == 3'b011);
      run(1'b0, IW'($urandom_range(0, 4095)), ins, 1'b0);
    end

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) gap(int'($urandom_range(1, 3)));
      run(1'($urandom_range(0, 1)), IW'($urandom_range(0, 4095)),
          IW'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
    end

    gap(2);
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
